// File: rtl/video_timing_pkg.sv
// Shared types and mode arithmetic for the video timing generator.
// The default constants describe 800x600 at 60 Hz with a 40 MHz pixel clock.
package video_timing_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2
  } vtg_state_e;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth register pipeline for a small control bundle; DEPTH=0 is a plain wire.
// Latency DEPTH cycles, no backpressure; async reset loads every stage with RESET_VAL.
module sig_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_dat = i_dat;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
        end else begin
          r_pipe[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_dat = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator: hs/vs/de, coordinates and frame/line markers.
// Coordinates 1 cycle after the counters, sync/de/markers LEAD cycles later; stop/start only on frame edges.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COORD_W  = 10,
  parameter int LEAD     = 0
) (
  input  logic               pixelClk,
  input  logic               aRst,
  input  logic               enable,
  output logic               stopped,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               frameStart,
  output logic               lineStart,
  output logic [7:0]         frameCnt
);

  localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HCW      = cnt_width(H_TOTAL);
  localparam int VCW      = cnt_width(V_TOTAL);
  localparam int HS_BEG   = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_BEG   = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);
  localparam int DW       = 6;
  // Bundle order: {stopped, frameStart, lineStart, vs, hs, de}
  localparam logic [DW-1:0] LINE_RST = {1'b1, 1'b0, 1'b0, ~VS_POL, ~HS_POL, 1'b0};

  vtg_state_e         r_state, w_state_nxt;
  logic [HCW-1:0]     r_hcnt;
  logic [VCW-1:0]     r_vcnt;
  logic [7:0]         r_frame_cnt;
  logic [COORD_W-1:0] r_pixel_x, r_pixel_y;

  logic w_active, w_h_last, w_v_last, w_frame_end;
  logic w_de_raw, w_hs_act, w_vs_act, w_ls_raw, w_fs_raw;
  logic [DW-1:0] w_line_in, w_line_out;

  assign w_active    = (r_state != STOPPED);
  assign w_h_last    = (int'(r_hcnt) == H_TOTAL - 1);
  assign w_v_last    = (int'(r_vcnt) == V_TOTAL - 1);
  assign w_frame_end = w_active && w_h_last && w_v_last;

  always_ff @(posedge pixelClk or posedge aRst) begin
    if (aRst) r_state <= STOPPED;
    else      r_state <= w_state_nxt;
  end

  // Leaving RUNNING/DRAINING is only allowed on the last pixel of a frame.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      STOPPED:  if (enable) w_state_nxt = RUNNING;
      RUNNING:  if (!enable) w_state_nxt = w_frame_end ? STOPPED : DRAINING;
      DRAINING: begin
        if (enable)           w_state_nxt = RUNNING;
        else if (w_frame_end) w_state_nxt = STOPPED;
      end
      default:  w_state_nxt = STOPPED;
    endcase
  end

  always_ff @(posedge pixelClk or posedge aRst) begin
    if (aRst) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
    end else if (w_active) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + VCW'(1);
      end else begin
        r_hcnt <= r_hcnt + HCW'(1);
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
    end else begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end
  end

  assign w_de_raw = w_active && (int'(r_hcnt) < H_ACTIVE) && (int'(r_vcnt) < V_ACTIVE);
  assign w_hs_act = w_active && (int'(r_hcnt) >= HS_BEG) && (int'(r_hcnt) < HS_END);
  assign w_vs_act = w_active && (int'(r_vcnt) >= VS_BEG) && (int'(r_vcnt) < VS_END);
  assign w_ls_raw = w_de_raw && (r_hcnt == '0);
  assign w_fs_raw = w_ls_raw && (r_vcnt == '0);

  assign w_line_in = {~w_active, w_fs_raw, w_ls_raw,
                      w_vs_act ? VS_POL : ~VS_POL,
                      w_hs_act ? HS_POL : ~HS_POL,
                      w_de_raw};

  always_ff @(posedge pixelClk or posedge aRst) begin
    if (aRst) begin
      r_pixel_x <= '0;
      r_pixel_y <= '0;
    end else begin
      r_pixel_x <= w_de_raw ? COORD_W'(r_hcnt) : '0;
      r_pixel_y <= (int'(r_vcnt) < V_ACTIVE) ? COORD_W'(r_vcnt) : '0;
    end
  end

  // One stage aligns with the coordinate register, the remaining LEAD stages trail it.
  sig_delay_line #(
    .WIDTH     (DW),
    .DEPTH     (LEAD + 1),
    .RESET_VAL (LINE_RST)
  ) u_line_dly (
    .i_clk (pixelClk),
    .i_rst (aRst),
    .i_dat (w_line_in),
    .o_dat (w_line_out)
  );

  assign {stopped, frameStart, lineStart, vs, hs, de} = w_line_out;
  assign pixelX   = r_pixel_x;
  assign pixelY   = r_pixel_y;
  assign frameCnt = r_frame_cnt;

endmodule
